// File: rtl/mac_pe_param_if.sv
// mac_pe_param_if: operand/result handshake bundle for the MAC processing element.
// master drives operands and consumes results; slave is the PE.
interface mac_pe_param_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int OUT_W  = 8
);
  logic [1:0]               mode_i;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] pe_in;
  logic signed [DATA_W-1:0] pe_filter;
  logic signed [ACC_W-1:0]  psum_in;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  pe_out;
  logic                     window_done;

  modport master (
    output mode_i, in_valid, pe_in, pe_filter, psum_in, out_ready,
    input  in_ready, out_valid, pe_out, window_done
  );

  modport slave (
    input  mode_i, in_valid, pe_in, pe_filter, psum_in, out_ready,
    output in_ready, out_valid, pe_out, window_done
  );
endinterface

// File: rtl/mac_pe_param.sv
// mac_pe_param: two-stage signed multiply-accumulate PE. Stage 1 registers one
// operand pair per cycle; stage 2 multiplies and accumulates KERNEL_LEN products,
// then loads a held, backpressured output register.
// Optional feature macro: PE_SAT_EN -- when defined, pe_out is the window result
// clamped to the signed OUT_W range; otherwise it is the truncated low bits.
module mac_pe_param #(
  parameter int DATA_W     = 8,
  parameter int KERNEL_LEN = 9,
  parameter int ACC_W      = 20,
  parameter int OUT_W      = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  mac_pe_param_if.slave   io_bus
);
  localparam int CNT_W  = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1;
  localparam int PROD_W = 2 * DATA_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KERNEL_LEN - 1);

  generate
    if (KERNEL_LEN < 1) begin : g_bad_klen
      $error("mac_pe_param: KERNEL_LEN must be >= 1");
    end
    if (ACC_W < PROD_W + $clog2(KERNEL_LEN)) begin : g_bad_accw
      $error("mac_pe_param: ACC_W too narrow for KERNEL_LEN products");
    end
    if (OUT_W > ACC_W) begin : g_bad_outw
      $error("mac_pe_param: OUT_W must not exceed ACC_W");
    end
  endgenerate

  logic signed [DATA_W-1:0] r_s1_in, r_s1_filter;
  logic [1:0]               r_s1_mode;
  logic                     r_s1_valid;
  logic signed [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]         r_cnt;
  logic signed [OUT_W-1:0]  r_out;
  logic                     r_out_valid;
  logic                     r_window_done;

  logic                     w_clear, w_stall, w_accept, w_fire, w_last;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext, w_psum, w_result;
  logic signed [OUT_W-1:0]  w_out;

  // mode 11 is reserved and behaves as a clear
  assign w_clear  = (io_bus.mode_i == 2'b00) || (io_bus.mode_i == 2'b11);
  assign w_stall  = r_out_valid && !io_bus.out_ready;
  assign w_accept = io_bus.in_valid && io_bus.in_ready;
  // a clear discards any element sitting in stage 1
  assign w_fire   = r_s1_valid && !w_stall && !w_clear;
  assign w_last   = (r_cnt == CNT_LAST);

  assign w_prod     = r_s1_in * r_s1_filter;
  assign w_prod_ext = ACC_W'(w_prod);
  // chaining is decided by the element carrying the last product
  assign w_psum     = (r_s1_mode == 2'b10) ? io_bus.psum_in : '0;
  assign w_result   = r_acc + w_prod_ext + w_psum;

`ifdef PE_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((longint'(1) << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
  // clamp the window result to the signed output range
  always_comb begin
    w_out = w_result[OUT_W-1:0];
    if (w_result > SAT_MAX)      w_out = SAT_MAX[OUT_W-1:0];
    else if (w_result < SAT_MIN) w_out = SAT_MIN[OUT_W-1:0];
  end
`else
  assign w_out = w_result[OUT_W-1:0];
`endif

  assign io_bus.in_ready    = !w_stall && !w_clear;
  assign io_bus.out_valid   = r_out_valid;
  assign io_bus.pe_out      = r_out;
  assign io_bus.window_done = r_window_done;

  // stage 1: capture the accepted operand pair and its mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_in     <= '0;
      r_s1_filter <= '0;
      r_s1_mode   <= 2'b00;
    end else if (w_clear) begin
      r_s1_valid <= 1'b0;
    end else if (!w_stall) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_in     <= io_bus.pe_in;
        r_s1_filter <= io_bus.pe_filter;
        r_s1_mode   <= io_bus.mode_i;
      end
    end
  end

  // stage 2: accumulate products and count positions within the window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_clear) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_fire) begin
      if (w_last) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= r_acc + w_prod_ext;
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // output register: load on window completion, drop valid once consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out         <= '0;
      r_out_valid   <= 1'b0;
      r_window_done <= 1'b0;
    end else begin
      r_window_done <= w_fire && w_last;
      if (w_fire && w_last) begin
        r_out       <= w_out;
        r_out_valid <= 1'b1;
      end else if (io_bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end
endmodule
